cdc_pulse_scheduler: RTL

Fast-domain scheduler that shares one fast-to-slow pulse CDC handshake channel among N_REQ requesters.
- Captures single-cycle request pulses as sticky pending bits.
- Picks one requester per transfer by round-robin.
- Issues exactly one pulse into the channel, with a tag identifying the winner.
- Waits for the channel handshake to complete plus a programmable guard gap before the next issue.
- Flags requests lost because a pending event for the same requester was still outstanding.

---
 rtl/cdc_sched_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/cdc_pulse_scheduler.sv | 92 +++++++++
 3 files changed

// File: rtl/cdc_sched_pkg.sv
// Shared types and helpers for the pulse CDC scheduler and its arbiter.
package cdc_sched_pkg;

    localparam int unsigned MAX_REQ = 16;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StIssue  = 3'd1,
        StSettle = 3'd2,
        StWait   = 3'd3,
        StGap    = 3'd4
    } sched_state_e;

    // Ceiling log2, never below 1 so a tag always has at least one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of pend searching upward from pointer.
module rr_arbiter
    import cdc_sched_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned W = clog2(N)
) (
    input  logic [N-1:0] pend,
    input  logic [W-1:0] pointer,
    output logic         grant_valid,
    output logic [W-1:0] grant_idx
);

    int unsigned idx;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = (32'(pointer) + off) % N;
            if (!grant_valid && pend[idx[W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = idx[W-1:0];
            end
        end
    end

endmodule

// File: rtl/cdc_pulse_scheduler.sv
// Shares one fast-to-slow pulse CDC channel among N_REQ requesters: sticky pending
// capture, round-robin grant, single issue pulse, then wait for busy plus a guard gap.
module cdc_pulse_scheduler
    import cdc_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned GAP_W = 8,
    localparam int unsigned TAG_W = clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             chan_busy_i,
    input  logic [GAP_W-1:0] gap_cfg_i,
    input  logic             drop_clr_i,
    output logic             pulse_o,
    output logic [TAG_W-1:0] tag_o,
    output logic [N_REQ-1:0] pend_o,
    output logic [N_REQ-1:0] drop_o,
    output logic             idle_o
);

    sched_state_e     state_q, state_d;
    logic [N_REQ-1:0] pend_q, pend_d, drop_q, drop_d, drop_set, grant_mask;
    logic [TAG_W-1:0] ptr_q, ptr_nxt, tag_q, grant_idx;
    logic [GAP_W-1:0] gap_q;
    logic             pulse_q, idle_q, grant_valid, grant;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .pend        (pend_q),
        .pointer     (ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        grant      = (state_q == StIdle) && enable_i && !chan_busy_i && grant_valid;
        grant_mask = '0;
        if (grant) grant_mask[grant_idx] = 1'b1;
        ptr_nxt = (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;

        // A request landing on a bit being granted this cycle re-arms it without a drop.
        pend_d   = (pend_q & ~grant_mask) | req_i;
        drop_set = req_i & pend_q & ~grant_mask;
        drop_d   = (drop_clr_i ? '0 : drop_q) | drop_set;

        state_d = state_q;
        unique case (state_q)
            StIdle:   if (grant) state_d = StIssue;
            StIssue:  state_d = StSettle;
            StSettle: state_d = StWait;
            StWait:   if (!chan_busy_i) state_d = (gap_q != '0) ? StGap : StIdle;
            StGap:    if (gap_q == GAP_W'(1)) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q <= StIdle;
            pend_q  <= '0;
            drop_q  <= '0;
            ptr_q   <= '0;
            tag_q   <= '0;
            gap_q   <= '0;
            pulse_q <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            pulse_q <= grant;
            idle_q  <= (state_d == StIdle) && (pend_d == '0);
            if (grant) begin
                tag_q <= grant_idx;
                ptr_q <= ptr_nxt;
            end
            if (state_q == StSettle) gap_q <= gap_cfg_i;
            else if (state_q == StGap) gap_q <= gap_q - 1'b1;
        end
    end

    assign pulse_o = pulse_q;
    assign tag_o   = tag_q;
    assign pend_o  = pend_q;
    assign drop_o  = drop_q;
    assign idle_o  = idle_q;

endmodule
